// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the fetch PC sequencer:
//   - seq_state_e      : redirect/flush FSM states (RUN, FLUSH_BR, FLUSH_JMP)
//   - DEFAULT_RESET_PC : default PC loaded on reset
//   - DEFAULT_PC_INC   : default sequential PC increment (bytes)
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_INC   = 4;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH_BR  = 2'd1,
        FLUSH_JMP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/br_target_gen.sv
// -----------------------------------------------------------------------------
// br_target_gen
// Combinational redirect-target computation for the PC sequencer.
// Ports:
//   br_pc4     in  [31:0] PC+4 of the branch in EX
//   br_imm     in  [31:0] sign-extended branch offset, in words
//   jmp_pc4    in  [31:0] PC+4 of the jump in ID
//   jmp_index  in  [25:0] J-type instruction index
//   br_target  out [31:0] br_pc4 + br_imm*4, wrapping modulo 2^32
//   jmp_target out [31:0] {jmp_pc4[31:28], jmp_index, 2'b00}
// -----------------------------------------------------------------------------
module br_target_gen (
    input  logic [31:0] br_pc4,
    input  logic [31:0] br_imm,
    input  logic [31:0] jmp_pc4,
    input  logic [25:0] jmp_index,
    output logic [31:0] br_target,
    output logic [31:0] jmp_target
);

    // Word offset becomes a byte offset; the 32-bit sum wraps naturally.
    assign br_target  = br_pc4 + (br_imm << 2);

    // Jumps stay inside the current 256 MB region selected by jmp_pc4[31:28].
    assign jmp_target = {jmp_pc4[31:28], jmp_index, 2'b00};

    // Only the region bits of jmp_pc4 matter for a jump.
    logic unused_jmp_pc4_low;
    assign unused_jmp_pc4_low = ^jmp_pc4[27:0];

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch PC register with branch/jump redirect and pipeline-flush FSM.
// A taken EX branch beats an ID jump (it is older). A redirect is applied
// even while stalled; the cycle after a redirect is a one-cycle flush state
// in which br_valid/jmp_valid are wrong-path and ignored.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   PC_INC    sequential increment
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall                    hold the PC (no redirect pending)
//   br_valid, br_taken       resolved EX branch and its outcome
//   br_imm, br_pc4           branch offset (words) and branch PC+4
//   jmp_valid, jmp_index     J-type instruction in ID and its index
//   jmp_pc4                  jump PC+4
//   pc                       registered fetch address
//   pc_plus4                 pc + PC_INC (combinational)
//   flush_if_id, flush_id_ex registered flush strobes
//   br_count                 saturating count of accepted taken branches
//                            (only with macro PC_BRANCH_COUNT_EN)
// -----------------------------------------------------------------------------
module pc_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_INC   = DEFAULT_PC_INC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_imm,
    input  logic [31:0] br_pc4,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_index,
    input  logic [31:0] jmp_pc4,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef PC_BRANCH_COUNT_EN
    output logic [15:0] br_count,
`endif
    output logic        flush_if_id,
    output logic        flush_id_ex
);

    seq_state_e  state, next_state;
    logic [31:0] next_pc;
    logic [31:0] br_target, jmp_target;
    logic        br_accept;

    br_target_gen u_target (
        .br_pc4     (br_pc4),
        .br_imm     (br_imm),
        .jmp_pc4    (jmp_pc4),
        .jmp_index  (jmp_index),
        .br_target  (br_target),
        .jmp_target (jmp_target)
    );

    assign pc_plus4 = pc + 32'(PC_INC);

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = RUN;
        next_pc    = stall ? pc : pc_plus4;
        br_accept  = 1'b0;
        case (state)
            RUN: begin
                if (br_valid && br_taken) begin
                    next_pc    = br_target;
                    next_state = FLUSH_BR;
                    br_accept  = 1'b1;
                end else if (jmp_valid) begin
                    next_pc    = jmp_target;
                    next_state = FLUSH_JMP;
                end
            end
            // Flush states: redirect inputs are wrong-path; sequential rule only.
            default: ;
        endcase
    end

    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            // Flush strobes are registered alongside the state they mirror.
            flush_if_id <= (next_state != RUN);
            flush_id_ex <= (next_state == FLUSH_BR);
        end
    end

`ifdef PC_BRANCH_COUNT_EN
    logic [15:0] br_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q <= 16'h0000;
        end else if (br_accept && (br_count_q != 16'hFFFF)) begin
            br_count_q <= br_count_q + 16'h0001;
        end
    end

    assign br_count = br_count_q;
`else
    logic unused_br_accept;
    assign unused_br_accept = br_accept;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model. Define
// PC_BRANCH_COUNT_EN to also exercise the branch counter.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] INC    = 32'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_valid, br_taken, jmp_valid;
    logic [31:0] br_imm, br_pc4, jmp_pc4;
    logic [25:0] jmp_index;
    logic [31:0] pc, pc_plus4;
    logic        flush_if_id, flush_id_ex;
`ifdef PC_BRANCH_COUNT_EN
    logic [15:0] br_count;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model: current pc, whether the last edge took a redirect
    // (making this cycle wrong-path), expected flush strobes, branch count.
    logic [31:0] m_pc;
    logic        m_after_redirect;
    logic        m_fif, m_fex;
    int unsigned m_count;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .br_imm      (br_imm),
        .br_pc4      (br_pc4),
        .jmp_valid   (jmp_valid),
        .jmp_index   (jmp_index),
        .jmp_pc4     (jmp_pc4),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
`ifdef PC_BRANCH_COUNT_EN
        .br_count    (br_count),
`endif
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + INC);
        check("flush_if_id", 32'(flush_if_id), 32'(m_fif));
        check("flush_id_ex", 32'(flush_id_ex), 32'(m_fex));
`ifdef PC_BRANCH_COUNT_EN
        check("br_count", 32'(br_count), m_count);
`endif
    endtask

    task automatic model_reset();
        m_pc             = RST_PC;
        m_after_redirect = 1'b0;
        m_fif            = 1'b0;
        m_fex            = 1'b0;
        m_count          = 0;
    endtask

    // Assert reset mid-cycle, check the immediate effect, release away from edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_pc", pc, RST_PC);
        check("rst_flush", 32'({flush_if_id, flush_id_ex}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_model();
    endtask

    // Apply one cycle of inputs, advance the model, clock, and compare.
    task automatic step(input logic s, input logic bv, input logic bt,
                        input logic [31:0] bimm, input logic [31:0] bpc4,
                        input logic jv, input logic [25:0] ji, input logic [31:0] jpc4);
        logic [31:0] nxt;
        logic        redir;
        stall = s; br_valid = bv; br_taken = bt; br_imm = bimm; br_pc4 = bpc4;
        jmp_valid = jv; jmp_index = ji; jmp_pc4 = jpc4;
        redir = 1'b0;
        m_fif = 1'b0;
        m_fex = 1'b0;
        if (!m_after_redirect && bv && bt) begin
            nxt   = bpc4 + bimm * 32'd4;
            redir = 1'b1;
            m_fif = 1'b1;
            m_fex = 1'b1;
            if (m_count < 32'hFFFF) m_count++;
        end else if (!m_after_redirect && jv) begin
            nxt   = {jpc4[31:28], ji, 2'b00};
            redir = 1'b1;
            m_fif = 1'b1;
        end else begin
            nxt = s ? m_pc : m_pc + INC;
        end
        m_pc             = nxt;
        m_after_redirect = redir;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle(input logic s);
        step(s, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
        br_imm = '0; br_pc4 = '0; jmp_pc4 = '0; jmp_index = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b0); idle(1'b0);

        // Reset mid-stream, right after a redirect so a flush is pending.
        step(1'b0, 1'b1, 1'b1, 32'h10, 32'h40, 1'b0, 26'h0, 32'h0);
        do_reset();
        idle(1'b0); check("seq_4", pc, 32'h4);
        idle(1'b0); check("seq_8", pc, 32'h8);
        idle(1'b0); check("seq_c", pc, 32'hC);

        // Get to 0x100 via a jump; stall through the flush cycle to hold it.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 26'h40, 32'h0);
        idle(1'b1); check("hold_100", pc, 32'h100);

        // Taken branch with negative offset.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h104, 1'b0, 26'h0, 32'h0);
        check("br_target", pc, 32'hFC);
        check("br_flush", 32'({flush_if_id, flush_id_ex}), 32'b11);
        idle(1'b0);
        check("after_br", pc, 32'h100);
        check("br_flush_end", 32'({flush_if_id, flush_id_ex}), 32'b00);

        // Jump while stalled.
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 26'h40, 32'h4000_0010);
        check("jmp_target", pc, 32'h4000_0100);
        check("jmp_flush", 32'({flush_if_id, flush_id_ex}), 32'b10);
        idle(1'b0);
        check("jmp_flush_end", 32'({flush_if_id, flush_id_ex}), 32'b00);

        // Branch and jump together: branch wins; next-cycle branch ignored.
        step(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 1'b1, 26'hC0, 32'h0);
        check("simul_pc", pc, 32'h200);
        check("simul_flush", 32'({flush_if_id, flush_id_ex}), 32'b11);
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 1'b1, 26'h1, 32'h0);
        check("wrong_path", pc, 32'h204);
        idle(1'b0);

        // Wraparound of sequential and branch-target arithmetic.
        step(1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0, 26'h0, 32'h0);
        idle(1'b1);
        check("wrap_plus4", pc_plus4, 32'h0);
        idle(1'b0);
        check("wrap_pc", pc, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFF0, 1'b0, 26'h0, 32'h0);
        check("wrap_br", pc, 32'h10);
        idle(1'b0);

        // Not-taken branch is no redirect.
        step(1'b0, 1'b1, 1'b0, 32'h40, 32'h800, 1'b0, 26'h0, 32'h0);
        check("not_taken", pc, 32'h18);

`ifdef PC_BRANCH_COUNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'h4, 32'h100, 1'b0, 26'h0, 32'h0);
            idle(1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 32'h4, 32'h100, 1'b0, 26'h0, 32'h0);
        check("count_3", 32'(br_count), 32'd3);
        force dut.br_count_q = 16'hFFFF;
        #1;
        release dut.br_count_q;
        m_count = 32'hFFFF;
        step(1'b0, 1'b1, 1'b1, 32'h4, 32'h100, 1'b0, 26'h0, 32'h0);
        check("count_sat", 32'(br_count), 32'hFFFF);
        idle(1'b0);
`endif

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(3) == 0,
                     $urandom_range(3) == 0,
                     $urandom_range(1) == 1,
                     ($urandom_range(1) == 1) ? $urandom() : 32'($urandom_range(64)),
                     $urandom(),
                     $urandom_range(4) == 0,
                     26'($urandom()),
                     $urandom());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, as the PC value loaded on reset.
REQ-002 The block SHALL provide parameter PC_INC, default 4, as the sequential PC increment.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, is the reset; it SHALL be asynchronous and active-high.
REQ-005 Port stall, input, 1, is the hazard-unit request to hold the PC.
REQ-006 Port br_valid, input, 1, indicates a resolved branch is present in EX.
REQ-007 Port br_taken, input, 1, is the EX branch outcome; it is qualified by br_valid.
REQ-008 Port br_imm, input, 32, is the sign-extended branch offset in words.
REQ-009 Port br_pc4, input, 32, is PC+4 of the EX branch.
REQ-010 Port jmp_valid, input, 1, indicates a J-type instruction is present in ID.
REQ-011 Port jmp_index, input, 26, is the jump instruction index.
REQ-012 Port jmp_pc4, input, 32, is PC+4 of the ID jump.
REQ-013 Port pc, output, 32, is the current fetch address (registered).
REQ-014 Port pc_plus4, output, 32, SHALL equal pc + PC_INC, modulo 2^32 (combinational).
REQ-015 Port flush_if_id, output, 1, is the registered flush of the IF/ID register.
REQ-016 Port flush_id_ex, output, 1, is the registered flush of the ID/EX register.

Function
REQ-017 The branch target SHALL be br_pc4 + (br_imm << 2), truncated to 32 bits; overflow SHALL wrap.
REQ-018 The jump target SHALL be {jmp_pc4[31:28], jmp_index, 2'b00}.
REQ-019 The FSM SHALL have three states: RUN, FLUSH_BR and FLUSH_JMP.
REQ-020 In RUN, br_valid && br_taken SHALL load pc with the branch target at the next edge, regardless of stall, and the FSM SHALL go to FLUSH_BR.
REQ-021 In RUN, jmp_valid without a taken branch SHALL load pc with the jump target at the next edge, regardless of stall, and the FSM SHALL go to FLUSH_JMP.
REQ-022 When a taken branch and a jump occur in the same cycle, the branch SHALL win, because it is the older instruction.
REQ-023 In RUN with no redirect, pc SHALL hold when stall=1 and SHALL advance by PC_INC otherwise; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-024 In FLUSH_BR, flush_if_id=1 and flush_id_ex=1 for exactly one cycle, and the FSM SHALL then return to RUN.
REQ-025 In FLUSH_JMP, flush_if_id=1 and flush_id_ex=0 for exactly one cycle, and the FSM SHALL then return to RUN.
REQ-026 In FLUSH_BR and FLUSH_JMP, br_valid and jmp_valid SHALL be ignored as wrong-path; pc SHALL follow the rule of REQ-023.
REQ-027 Outside the FLUSH states, both flush outputs SHALL be 0.
REQ-028 A not-taken branch (br_valid=1, br_taken=0) SHALL behave as no redirect.

Reset
REQ-029 Assertion of rst SHALL immediately set pc=RESET_PC, state=RUN, flush_if_id=0 and flush_id_ex=0.
REQ-030 A pending redirect or flush in progress when rst asserts SHALL be discarded.
REQ-031 The first post-reset fetch SHALL be RESET_PC, and pc SHALL advance on the first edge after rst deasserts, unless stalled.

Configuration
REQ-032 With macro PC_BRANCH_COUNT_EN defined, the block SHALL add output br_count[15:0], which increments on every accepted taken branch, saturates at 16'hFFFF, and resets to 0.
REQ-033 Without PC_BRANCH_COUNT_EN, the br_count port and its counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-034 Shared package pipe_pkg SHALL hold the FSM state enum (RUN, FLUSH_BR, FLUSH_JMP) and the default constants for RESET_PC and PC_INC.
REQ-035 Target computation (REQ-017, REQ-018) SHALL live in a combinational sub-module named br_target_gen; the FSM and PC register SHALL live in pc_sequencer.

Verification
REQ-036 Reset check: pulse rst mid-stream, then run 3 cycles with no stall -> pc=0x0, then 0x4, 0x8, 0xC; flushes 0 throughout.
REQ-037 Taken branch: pc=0x100, br_pc4=0x104, br_imm=0xFFFF_FFFE, br_taken=1 -> next pc=0xFC; flush_if_id=flush_id_ex=1 for one cycle; then pc=0x100.
REQ-038 Jump under stall: stall=1, jmp_valid=1, jmp_pc4=0x4000_0010, jmp_index=0x0000_040 -> next pc=0x4000_0100; flush_if_id=1, flush_id_ex=0 for one cycle.
REQ-039 Simultaneous events: branch target 0x200 and jump target 0x300 in the same cycle -> pc=0x200, FLUSH_BR; a br_valid in the following cycle is ignored.
REQ-040 Wrap: pc=0xFFFF_FFFC with no stall -> pc=0x0; br_pc4=0xFFFF_FFF0, br_imm=8 -> target 0x0000_0010.
REQ-041 Counter (PC_BRANCH_COUNT_EN defined): 3 taken branches and 1 not-taken -> br_count=3; force the counter to 0xFFFF, then one more taken branch -> br_count stays 0xFFFF.
